// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative radix-2 restoring divider for DIV/DIVU
//
// Responder side of the E-stage multiply/divide stall handshake. One quotient
// bit is produced per cycle; the E stage stays stalled until the HI/LO pair is
// ready. Signed operands are divided as magnitudes and fixed up at the end.

module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             signQ;
  logic             signR;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic             accept;
  logic             divByZero;

  logic [WIDTH:0]   remShift;
  logic [WIDTH+1:0] trial;
  logic             takeBit;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] quoFix;
  logic [WIDTH-1:0] remFix;
  logic             lastIter;

  // Operand magnitudes; WIDTH-bit negation keeps INT_MIN as 0x80..0 unsigned.
  always_comb begin
    aNeg      = signed_i & a_i[WIDTH-1];
    bNeg      = signed_i & b_i[WIDTH-1];
    aMag      = aNeg ? ({WIDTH{1'b0}} - a_i) : a_i;
    bMag      = bNeg ? ({WIDTH{1'b0}} - b_i) : b_i;
    accept    = (state == StIdle) & start_i & ~annul_i;
    divByZero = (b_i == {WIDTH{1'b0}});
  end

  // One restoring step: shift {rem,quo} left, trial-subtract, keep on no borrow.
  always_comb begin
    remShift = {rem, quo[WIDTH-1]};
    trial    = {1'b0, remShift} - {2'b00, divisor};
    takeBit  = ~trial[WIDTH+1];
    remNext  = takeBit ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], takeBit};
    lastIter = (count == CntW'(WIDTH - 1));
    quoFix   = signQ ? ({WIDTH{1'b0}} - quoNext) : quoNext;
    remFix   = signR ? ({WIDTH{1'b0}} - remNext) : remNext;
  end

  // The E stage is held while a request is being taken or iterated; annul releases it.
  assign stall_o = ~annul_i & (((state == StIdle) & start_i) | (state == StRun));

  // Control FSM: IDLE -> RUN -> DONE -> IDLE, with annul returning to IDLE from anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
    end else if (annul_i) begin
      state <= StIdle;
    end else begin
      case (state)
        StIdle: begin
          if (start_i) begin
            state <= divByZero ? StDone : StRun;
          end
        end
        StRun: begin
          if (lastIter) begin
            state <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Iteration datapath: latch magnitudes and signs on accept, then step once per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      divisor <= bMag;
      rem     <= '0;
      quo     <= aMag;
      signQ   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      signR   <= signed_i & a_i[WIDTH-1];
    end else if ((state == StRun) && !annul_i) begin
      count   <= count + 1'b1;
      rem     <= remNext;
      quo     <= quoNext;
    end
  end

  // HI/LO results are written only on entry to DONE, and done_o marks that one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (accept && divByZero) begin
        // Divide by zero: quotient all ones, remainder is the raw dividend, no sign fix.
        done_o <= 1'b1;
        lo_o   <= {WIDTH{1'b1}};
        hi_o   <= a_i;
      end else if ((state == StRun) && lastIter && !annul_i) begin
        done_o <= 1'b1;
        lo_o   <= quoFix;
        hi_o   <= remFix;
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - directed self-checking bench for div_iter_unit

module tb_div_iter_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks;
  int errors;

  div_iter_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide at the next negedge, hold start until done_o, then check timing and result.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expLo,
                         input logic [31:0] expHi, input int expStall);
    int stallCnt;
    int doneCyc;
    logic seen;
    logic [31:0] gotLo;
    logic [31:0] gotHi;
    stallCnt = 0;
    doneCyc  = -1;
    seen     = 1'b0;
    gotLo    = '0;
    gotHi    = '0;
    @(negedge clk);
    signed_i = sgn;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (stall_o === 1'b1) stallCnt++;
      if (done_o === 1'b1) begin
        seen    = 1'b1;
        doneCyc = k;
        gotLo   = lo_o;
        gotHi   = hi_o;
        start_i = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk({tag, " done_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, " stall_cycles"}, stallCnt, expStall);
    chk({tag, " done_cycle"}, doneCyc, expStall);
    chk({tag, " lo"}, gotLo, expLo);
    chk({tag, " hi"}, gotHi, expHi);
  endtask

  // Over n cycles, done_o and stall_o must stay low.
  task automatic quiet(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (done_o !== 1'b0 || stall_o !== 1'b0) bad++;
    end
    chk({tag, " quiet_cycles_bad"}, bad, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    annul_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset hi", hi_o, 32'h0);
    chk("reset lo", lo_o, 32'h0);
    chk("reset done", {31'b0, done_o}, 32'd0);
    chk("reset stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned divide and single-pulse done
    run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 33);
    quiet("after_divu_7_2", 3);

    // Signed divides with negative dividend / divisor
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run_div("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33);

    // Boundaries
    run_div("div_intmin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);

    // Divide by zero, short path, raw dividend in hi
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    quiet("after_div0", 2);
    run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);

    // annul_i together with start_i in IDLE is not accepted
    @(negedge clk);
    signed_i = 1'b0;
    a_i      = 32'd9;
    b_i      = 32'd3;
    start_i  = 1'b1;
    annul_i  = 1'b1;
    #1;
    chk("annul_idle stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    quiet("annul_idle", 40);
    chk("annul_idle lo kept", lo_o, 32'hFFFF_FFFF);
    chk("annul_idle hi kept", hi_o, 32'hFFFF_FFF9);

    // annul_i in RUN cycle 10
    @(negedge clk);
    signed_i = 1'b0;
    a_i      = 32'd7;
    b_i      = 32'd2;
    start_i  = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("annul_run stall_before", {31'b0, stall_o}, 32'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    chk("annul_run stall_during", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    chk("annul_run stall_next", {31'b0, stall_o}, 32'd0);
    quiet("annul_run", 40);
    chk("annul_run lo kept", lo_o, 32'hFFFF_FFFF);
    chk("annul_run hi kept", hi_o, 32'hFFFF_FFF9);

    // Reset mid-RUN clears outputs immediately, then a fresh divide works
    @(negedge clk);
    signed_i = 1'b0;
    a_i      = 32'd1000;
    b_i      = 32'd3;
    start_i  = 1'b1;
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    #1;
    chk("rst_mid hi", hi_o, 32'h0);
    chk("rst_mid lo", lo_o, 32'h0);
    chk("rst_mid done", {31'b0, done_o}, 32'd0);
    chk("rst_mid stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet("after_rst", 3);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // Back-to-back: second start sampled in the IDLE cycle after DONE
    run_div("b2b_divu_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33);
    run_div("b2b_div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    quiet("after_b2b", 3);
    chk("hold lo", lo_o, 32'hFFFF_FFF2);
    chk("hold hi", hi_o, 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
